// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- stall/flush sequencer for the five-stage MIPS pipeline.
//
// Combines the load-use hazard decision, a countdown that tracks the
// multi-cycle multiply/divide unit (MDU) and M-stage exception/ERET
// redirects into the enable/clear controls of the PC and the F/D and D/E
// stage registers. The M/W register is never touched by this block.
//
// Optional feature: define PIPE_CTRL_PERF_EN to add the stall_cnt and
// flush_cnt performance counters (ports and registers are absent otherwise).
//
// Ports:
//   clk         pipeline clock, rising edge
//   reset       synchronous, active-high reset
//   hz_stall_D  data hazard on the instruction in D
//   md_start_E  mult/div instruction in E this cycle
//   md_div_E    1 = div/divu, 0 = mult/multu (qualifies md_start_E)
//   md_use_D    instruction in D uses the MDU or HI/LO
//   exc_req_M   exception/interrupt taken on the M instruction
//   eret_M      eret in M
//   en_PC       PC write enable
//   en_D        F/D register enable
//   clr_E       insert bubble into D/E
//   flush       clear F/D, D/E, E/M
//   pc_sel      00 = sequential, 01 = exception handler, 10 = EPC
//   md_busy     MDU result not yet valid
//   stall_cnt   cycles with stall asserted   (PIPE_CTRL_PERF_EN only)
//   flush_cnt   cycles with flush asserted   (PIPE_CTRL_PERF_EN only)
module pipe_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hz_stall_D,
  input  logic        md_start_E,
  input  logic        md_div_E,
  input  logic        md_use_D,
  input  logic        exc_req_M,
  input  logic        eret_M,
  output logic        en_PC,
  output logic        en_D,
  output logic        clr_E,
  output logic        flush,
  output logic [1:0]  pc_sel,
  output logic        md_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic [3:0] md_cnt;
  logic       md_start_vld;
  logic       md_stall;
  logic       stall;

  assign flush = exc_req_M | eret_M;

  // The E instruction is younger than M, so a start that coincides with a
  // redirect belongs to a flushed instruction and must not launch the MDU.
  assign md_start_vld = md_start_E & ~flush;

  assign md_busy  = (md_cnt != 4'd0);
  // The current start is counted here so an MDU consumer directly behind the
  // starting instruction is held even before md_cnt has been loaded.
  assign md_stall = md_use_D & (md_busy | md_start_E);
  assign stall    = (hz_stall_D | md_stall) & ~flush;

  // MDU countdown: an operation already in flight keeps counting through a
  // flush, since its result is architecturally committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= 4'd0;
    end else if (md_start_vld) begin
      md_cnt <= md_div_E ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  always_comb begin
    en_PC  = 1'b1;
    en_D   = 1'b1;
    clr_E  = 1'b0;
    pc_sel = 2'b00;
    if (exc_req_M)   pc_sel = 2'b01;
    else if (eret_M) pc_sel = 2'b10;
    // On flush F/D stays enabled so it loads its clear value.
    if (flush) begin
      clr_E = 1'b1;
    end else if (stall) begin
      en_PC = 1'b0;
      en_D  = 1'b0;
      clr_E = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if (flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl with default parameters
// (MULT_CYCLES = 5, DIV_CYCLES = 10). Each table row is one clock cycle:
// inputs are driven just after the rising edge and outputs are sampled on
// the falling edge. Rows are applied in order, so md_busy expectations
// follow from the preceding rows.
module tb_pipe_ctrl;

  logic        clk;
  logic        reset;
  logic        hz_stall_D, md_start_E, md_div_E, md_use_D, exc_req_M, eret_M;
  logic        en_PC, en_D, clr_E, flush, md_busy;
  logic [1:0]  pc_sel;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  pipe_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .hz_stall_D (hz_stall_D),
    .md_start_E (md_start_E),
    .md_div_E   (md_div_E),
    .md_use_D   (md_use_D),
    .exc_req_M  (exc_req_M),
    .eret_M     (eret_M),
    .en_PC      (en_PC),
    .en_D       (en_D),
    .clr_E      (clr_E),
    .flush      (flush),
    .pc_sel     (pc_sel),
    .md_busy    (md_busy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row: inputs {hz, start, div, use, exc, eret};
  // expected {en_PC, en_D, clr_E, flush, pc_sel, md_busy}.
  typedef struct {
    logic       hz, start, div, md_use, exc, eret;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [6:0] RUN    = 7'b110_0_00_0;  // free running, idle MDU
  localparam logic [6:0] RUN_B  = 7'b110_0_00_1;  // free running, MDU busy
  localparam logic [6:0] STL    = 7'b001_0_00_0;  // stalled, idle MDU
  localparam logic [6:0] STL_B  = 7'b001_0_00_1;  // stalled, MDU busy
  localparam logic [6:0] EXC    = 7'b111_1_01_0;  // exception redirect
  localparam logic [6:0] EXC_B  = 7'b111_1_01_1;
  localparam logic [6:0] ERT    = 7'b111_1_10_0;  // eret redirect

  function automatic vec_t mk(input logic hz, start, div, md_use, exc, eret,
                              input logic [6:0] exp);
    vec_t r;
    r.hz = hz; r.start = start; r.div = div; r.md_use = md_use;
    r.exc = exc; r.eret = eret; r.exp = exp;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    hz_stall_D = r.hz;  md_start_E = r.start; md_div_E = r.div;
    md_use_D   = r.md_use; exc_req_M = r.exc; eret_M = r.eret;
  endtask

  task automatic idle_inputs();
    hz_stall_D = 0; md_start_E = 0; md_div_E = 0;
    md_use_D = 0; exc_req_M = 0; eret_M = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {en_PC, en_D, clr_E, flush, pc_sel, md_busy};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- build the vector table ----------------
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,0,0,0,0, RUN));
    // mult start with an MDU consumer in D: stall 1 + 5 cycles, released on 6th
    vecs.push_back(mk(0,1,0,1,0,0, STL));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,0,1,0,0, STL_B));
    vecs.push_back(mk(0,0,0,1,0,0, RUN));
    vecs.push_back(mk(0,0,0,0,0,0, RUN));
    // div start: stall 1 + 10 cycles
    vecs.push_back(mk(0,1,1,1,0,0, STL));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0,0,0,1,0,0, STL_B));
    vecs.push_back(mk(0,0,0,1,0,0, RUN));
    // single-cycle hazard stall
    vecs.push_back(mk(1,0,0,0,0,0, STL));
    vecs.push_back(mk(0,0,0,0,0,0, RUN));
    // exception + eret + hazard: exception wins, flush overrides stall
    vecs.push_back(mk(1,0,0,0,1,1, EXC));
    vecs.push_back(mk(0,0,0,0,0,1, ERT));
    // start coinciding with eret is discarded
    vecs.push_back(mk(0,1,1,0,0,1, ERT));
    vecs.push_back(mk(0,0,0,0,0,0, RUN));
    vecs.push_back(mk(0,0,0,0,0,0, RUN));
    // start coinciding with exception is discarded
    vecs.push_back(mk(0,1,0,0,1,0, EXC));
    vecs.push_back(mk(0,0,0,0,0,0, RUN));
    // div, exception (with MDU consumer in D) at busy cycle 3: still 10 busy cycles
    vecs.push_back(mk(0,1,1,0,0,0, RUN));
    vecs.push_back(mk(0,0,0,0,0,0, RUN_B));
    vecs.push_back(mk(0,0,0,0,0,0, RUN_B));
    vecs.push_back(mk(0,0,0,1,1,0, EXC_B));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0,0,0,0,0,0, RUN_B));
    vecs.push_back(mk(0,0,0,0,0,0, RUN));
    // back-to-back start reloads the counter
    vecs.push_back(mk(0,1,0,0,0,0, RUN));
    vecs.push_back(mk(0,0,0,0,0,0, RUN_B));
    vecs.push_back(mk(0,1,0,0,0,0, RUN_B));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,0,0,0,0, RUN_B));
    vecs.push_back(mk(0,0,0,0,0,0, RUN));

    // ---------------- reset state ----------------
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset_outputs", 32'(outs()), 32'(RUN));
`ifdef PIPE_CTRL_PERF_EN
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_flush_cnt", flush_cnt, 32'd0);
`endif
    next_cycle();
    reset = 1'b0;

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("row%0d", i), 32'(outs()), 32'(vecs[i].exp));
      next_cycle();
    end

    // ---------------- reset during a countdown ----------------
    idle_inputs();
    md_start_E = 1; md_div_E = 1;
    next_cycle();
    idle_inputs();
    next_cycle();
    @(negedge clk);
    check("busy_before_reset", 32'(md_busy), 32'd1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    md_use_D = 1;
    @(negedge clk);
    check("reset_mid_countdown", 32'(outs()), 32'(RUN));
    next_cycle();
    idle_inputs();

`ifdef PIPE_CTRL_PERF_EN
    // ---------------- performance counters ----------------
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    hz_stall_D = 1;
    repeat (3) next_cycle();
    hz_stall_D = 0;
    exc_req_M = 1;
    next_cycle();
    exc_req_M = 0;
    eret_M = 1; hz_stall_D = 1;   // flushed stall is not a stall
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("stall_cnt", stall_cnt, 32'd3);
    check("flush_cnt", flush_cnt, 32'd2);
    next_cycle();
    hz_stall_D = 1; exc_req_M = 0;
    next_cycle();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("stall_cnt_after_reset", stall_cnt, 32'd0);
    check("flush_cnt_after_reset", flush_cnt, 32'd0);
    next_cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
